fpcvt_pipe: RTL and testbench

- Streaming, parametrised successor to the combinational 12-bit two's-complement to 8-bit float converter.
- Accepts one signed integer per cycle over a valid/ready handshake and emits a sign/exponent/significand float. Encoded value = (-1)^S * M * 2^E.
- Adds a per-sample rounding mode, a saturation flag, backpressure and a 3-stage pipeline.
- Sits between the sample source and any float consumer.

---
 rtl/fpcvt_pipe.sv | 184 ++++++++++++++++++
 tb/tb_fpcvt_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpcvt_pipe.sv
// -----------------------------------------------------------------------------
// fpcvt_pipe
//   Streaming two's-complement integer to small float converter.
//   Encoded value = (-1)^S * M * 2^E, word layout {S, E[EXP_W-1:0], M[MAN_W-1:0]}
//   (no hidden bit). Three register stages:
//     stage 1 : sign / magnitude (most-negative input clamps to max magnitude)
//     stage 2 : normalise (leading-one detect, extract M and the round bit)
//     stage 3 : round (half away from zero or truncate), renormalise, saturate
//   Each stage loads when it is empty or the next stage drains it this cycle,
//   giving one sample per cycle and full backpressure.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   input sample valid
//   in_ready   converter can accept a sample (combinational from out_ready)
//   in_data    IN_W-bit two's-complement sample
//   in_rnd     0 = round half away from zero, 1 = truncate (travels with sample)
//   out_valid  output word valid
//   out_ready  consumer accepts the word
//   out_data   {sign, exp, significand}
//   out_sat    word was saturated to the largest representable magnitude
// -----------------------------------------------------------------------------
module fpcvt_pipe #(
  parameter int IN_W  = 12,
  parameter int EXP_W = 3,
  parameter int MAN_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_data,
  input  logic                     in_rnd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_data,
  output logic                     out_sat
);

  localparam int MAG_W = IN_W - 1;
  localparam int P_W   = $clog2(MAG_W + 1);

  // ---------------------------------------------------------------------------
  // Handshake: a stage may load when it is empty or its content moves on.
  // ---------------------------------------------------------------------------
  logic v1, v2, v3;
  logic load1, load2, load3;

  assign load3    = !v3 || out_ready;
  assign load2    = !v2 || load3;
  assign load1    = !v1 || load2;
  assign in_ready = load1;
  assign out_valid = v3;

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: sign and magnitude
  // ---------------------------------------------------------------------------
  logic             sign_c;
  logic [MAG_W-1:0] mag_c;

  assign sign_c = in_data[IN_W-1];

  // NOTE: every signal assigned in always_comb gets a default on entry so no
  // path leaves it unassigned; otherwise a latch is inferred.
  always_comb begin
    mag_c = in_data[MAG_W-1:0];
    if (sign_c) begin
      // Negating the most-negative value has no positive counterpart, so it
      // clamps to the largest magnitude instead of wrapping to zero.
      if (in_data[MAG_W-1:0] == '0) mag_c = '1;
      else                          mag_c = MAG_W'(-in_data);
    end
  end

  logic             s1, rnd1;
  logic [MAG_W-1:0] mag1;

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: leading-one detect and field extraction
  // ---------------------------------------------------------------------------
  logic [P_W-1:0]   lead_c;   // index of the leading one in mag1
  logic [P_W-1:0]   shift_c;  // right shift that puts the leading one at M's MSB
  logic [EXP_W-1:0] exp_c;
  logic [MAN_W-1:0] man_c;
  logic             rbit_c;

  always_comb begin
    lead_c = '0;
    for (int i = 0; i < MAG_W; i++) begin
      if (mag1[i]) lead_c = P_W'(i);
    end
    shift_c = lead_c - P_W'(MAN_W - 1);
    if (int'(mag1) < (2 ** MAN_W)) begin
      // Small values fit unchanged with E = 0 and are exact.
      exp_c  = '0;
      man_c  = mag1[MAN_W-1:0];
      rbit_c = 1'b0;
    end else begin
      exp_c  = EXP_W'(shift_c);
      man_c  = MAN_W'(mag1 >> shift_c);
      rbit_c = mag1[shift_c - P_W'(1)];
    end
  end

  logic             s2, rnd2, rbit2;
  logic [EXP_W-1:0] exp2;
  logic [MAN_W-1:0] man2;

  // ---------------------------------------------------------------------------
  // Stage 3 combinational: round, renormalise on carry-out, saturate
  // ---------------------------------------------------------------------------
  logic [MAN_W:0]     man_sum_c;
  logic [EXP_W:0]     exp_ext_c;  // one spare bit catches exponent overflow
  logic [MAN_W-1:0]   man_fin_c;
  logic               sat_c;
  logic [EXP_W+MAN_W:0] word_c;

  always_comb begin
    man_sum_c = {1'b0, man2} + (MAN_W+1)'(!rnd2 && rbit2);
    exp_ext_c = {1'b0, exp2};
    man_fin_c = man_sum_c[MAN_W-1:0];
    if (man_sum_c[MAN_W]) begin
      // M rounded up to 2^MAN_W: halve it and bump the exponent.
      man_fin_c = {1'b1, {(MAN_W-1){1'b0}}};
      exp_ext_c = exp_ext_c + 1'b1;
    end
    sat_c  = exp_ext_c[EXP_W];
    word_c = sat_c ? {s2, {EXP_W{1'b1}}, {MAN_W{1'b1}}}
                   : {s2, exp_ext_c[EXP_W-1:0], man_fin_c};
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and stage order inside the block does not matter.
  // NOTE: the data registers are reset as well as the valid bits; the pipeline
  // is small, and a defined out_data after reset is part of the interface.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      s1       <= 1'b0;
      rnd1     <= 1'b0;
      mag1     <= '0;
      s2       <= 1'b0;
      rnd2     <= 1'b0;
      rbit2    <= 1'b0;
      exp2     <= '0;
      man2     <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      if (load1) begin
        v1 <= in_valid;
        if (in_valid) begin
          s1   <= sign_c;
          rnd1 <= in_rnd;
          mag1 <= mag_c;
        end
      end
      if (load2) begin
        v2 <= v1;
        if (v1) begin
          s2    <= s1;
          rnd2  <= rnd1;
          rbit2 <= rbit_c;
          exp2  <= exp_c;
          man2  <= man_c;
        end
      end
      if (load3) begin
        v3 <= v2;
        if (v2) begin
          out_data <= word_c;
          out_sat  <= sat_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpcvt_pipe.sv
// -----------------------------------------------------------------------------
// tb_fpcvt_pipe
//   Self-checking bench for fpcvt_pipe at default parameters. Directed vectors
//   carry hand-derived expected words; random traffic is scored against an
//   arithmetic model (divide by a power of two, add half an ulp, compare with
//   the representable range). Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fpcvt_pipe;

  localparam int IN_W  = 12;
  localparam int EXP_W = 3;
  localparam int MAN_W = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_W-1:0]      in_data;
  logic                 in_rnd;
  logic                 out_valid;
  logic                 out_ready;
  logic [EXP_W+MAN_W:0] out_data;
  logic                 out_sat;

  always #5 clk = ~clk;

  fpcvt_pipe #(.IN_W(IN_W), .EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_rnd   (in_rnd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [8:0] exp_q[$];      // expected {sat, word} in accept order
  logic [8:0] pend_exp;      // expectation for the sample currently offered
  bit         acc, take, stall_prev;
  logic [8:0] held;
  int         cyc_n = 0;
  int         take_cnt, first_take, last_take;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: pick E so the magnitude divided by 2^E fits MAN_W bits, then
  // divide with or without adding half of 2^E, and check the range.
  function automatic logic [8:0] ref_model(input logic [IN_W-1:0] d, input bit trunc);
    int x, mag, e, q;
    bit sgn;
    x   = int'($signed(d));
    sgn = (x < 0);
    mag = sgn ? -x : x;
    if (mag > 2 ** (IN_W - 1) - 1) mag = 2 ** (IN_W - 1) - 1;
    e = 0;
    while ((mag / (2 ** e)) >= 2 ** MAN_W) e++;
    if (trunc || e == 0) q = mag / (2 ** e);
    else                 q = (mag + 2 ** (e - 1)) / (2 ** e);
    if (q == 2 ** MAN_W) begin
      q = 2 ** (MAN_W - 1);
      e++;
    end
    if (e > 2 ** EXP_W - 1) return {1'b1, sgn, 7'h7F};
    return {1'b0, sgn, 3'(e), 4'(q)};
  endfunction

  // One clock: score the handshake just before the edge, then advance to 1 ns
  // after it so the caller can drive the next inputs.
  task automatic cyc();
    @(negedge clk);
    acc  = in_valid && in_ready;
    take = out_valid && out_ready;
    if (stall_prev) begin
      chk("stall_valid_held", 32'(out_valid), 32'd1);
      chk("stall_data_held", 32'({out_sat, out_data}), 32'(held));
    end
    if (take) begin
      chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("out_word", 32'({out_sat, out_data}), 32'(exp_q.pop_front()));
      if (take_cnt == 0) first_take = cyc_n;
      last_take = cyc_n;
      take_cnt++;
    end
    stall_prev = out_valid && !out_ready;
    held       = {out_sat, out_data};
    if (acc) exp_q.push_back(pend_exp);
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic send(input logic [IN_W-1:0] d, input bit r, input logic [8:0] e);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_rnd   = r;
    pend_exp = e;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!acc && n < 50);
    chk("accept_in_time", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cyc();
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [IN_W-1:0] bp_d[6];
    logic [IN_W-1:0] rd;
    bit              rr;
    int              idx, accn, t;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_rnd = 1'b0; out_ready = 1'b1;
    pend_exp = '0; stall_prev = 1'b0; take_cnt = 0; first_take = 0; last_take = 0;
    #12;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_word", 32'({out_sat, out_data}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    // Rounding, streamed back to back; out_valid rises on the third edge
    // counting the edge that accepted the first sample.
    send(12'd44, 1'b0, 9'h02B);
    chk("lat_after_1", 32'(out_valid), 32'd0);
    send(12'd45, 1'b0, 9'h02B);
    chk("lat_after_2", 32'(out_valid), 32'd0);
    send(12'd46, 1'b0, 9'h02C);
    chk("lat_after_3", 32'(out_valid), 32'd1);
    send(12'd47, 1'b0, 9'h02C);
    drain(20);

    // Truncate, carry renormalisation, signs, small values, saturation.
    send(12'd47,     1'b1, 9'h02B);
    send(12'd31,     1'b0, 9'h028);
    send(12'd31,     1'b1, 9'h01F);
    send(12'd0,      1'b0, 9'h000);
    send(12'(-5),    1'b0, 9'h085);
    send(12'(-46),   1'b0, 9'h0AC);
    send(12'(-1),    1'b0, 9'h081);
    send(12'd15,     1'b0, 9'h00F);
    send(12'd2047,   1'b0, 9'h17F);
    send(12'(-2048), 1'b0, 9'h1FF);
    send(12'd1984,   1'b0, 9'h17F);
    send(12'd1920,   1'b0, 9'h07F);
    send(12'd1984,   1'b1, 9'h07F);
    drain(30);

    // Backpressure: six samples offered while the consumer stalls.
    bp_d[0] = 12'd100;  bp_d[1] = 12'(-300); bp_d[2] = 12'd7;
    bp_d[3] = 12'd1023; bp_d[4] = 12'(-17);  bp_d[5] = 12'd555;
    out_ready = 1'b0;
    idx = 0; accn = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (idx < 6);
      if (idx < 6) begin
        in_data = bp_d[idx]; in_rnd = 1'b0; pend_exp = ref_model(bp_d[idx], 1'b0);
      end
      cyc();
      if (acc) begin idx++; accn++; end
    end
    chk("bp_accepts", 32'(accn), 32'd3);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    take_cnt = 0;
    for (int c = 0; c < 40 && (idx < 6 || exp_q.size() != 0); c++) begin
      in_valid = (idx < 6);
      if (idx < 6) begin
        in_data = bp_d[idx]; in_rnd = 1'b0; pend_exp = ref_model(bp_d[idx], 1'b0);
      end
      cyc();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp_takes", 32'(take_cnt), 32'd6);
    chk("bp_no_gap", 32'(last_take - first_take), 32'd5);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset with three samples in flight.
    out_ready = 1'b0;
    send(12'd300, 1'b0, ref_model(12'd300, 1'b0));
    send(12'd301, 1'b0, ref_model(12'd301, 1'b0));
    send(12'd302, 1'b0, ref_model(12'd302, 1'b0));
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_word", 32'({out_sat, out_data}), 32'd0);
    exp_q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    chk("rst_release_ready", 32'(in_ready), 32'd1);
    repeat (5) cyc();
    chk("flushed_no_output", 32'(out_valid), 32'd0);
    send(12'd46, 1'b0, 9'h02C);
    t = 1;
    while (!out_valid && t < 10) begin
      cyc();
      t++;
    end
    chk("rst_next_latency", 32'(t), 32'd3);
    drain(10);

    // Random traffic with random stalls on both sides.
    for (int n = 0; n < 400; n++) begin
      rd = 12'($urandom);
      if ($urandom_range(0, 9) == 0) rd = ($urandom_range(0, 1) != 0) ? 12'h800 : 12'h7FF;
      rr = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      in_data   = rd;
      in_rnd    = rr;
      pend_exp  = ref_model(rd, rr);
      cyc();
    end
    out_ready = 1'b1;
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
